// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
// edge_detector : synchronizes an asynchronous level and emits one-cycle
//                 rising / falling / any-edge strobes in the clk domain.
// Revision 1.0
// ============================================================================
module edge_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rising_edge,
  output logic falling_edge,
  output logic any_edge,
  output logic din_sync
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset clears the whole chain, so a level held across release is seen as a new edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign din_sync     = sync_q[SYNC_STAGES-1];
  assign rising_edge  = din_sync & ~prev_q;
  assign falling_edge = ~din_sync & prev_q;
  assign any_edge     = rising_edge | falling_edge;

endmodule
`default_nettype wire

// File: tb/tb_edge_detector.sv
`default_nettype none
// Randomized + directed bench for edge_detector at SYNC_STAGES = 1, 2 and 3,
// scoreboarded against a sample-history reference model.
module tb_edge_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;

  logic [2:0] rise, fall, anye, dsync;

  always #5 clk = ~clk;

  edge_detector #(.SYNC_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din),
    .rising_edge(rise[0]), .falling_edge(fall[0]), .any_edge(anye[0]), .din_sync(dsync[0])
  );
  edge_detector #(.SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din),
    .rising_edge(rise[1]), .falling_edge(fall[1]), .any_edge(anye[1]), .din_sync(dsync[1])
  );
  edge_detector #(.SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .din(din),
    .rising_edge(rise[2]), .falling_edge(fall[2]), .any_edge(anye[2]), .din_sync(dsync[2])
  );

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] f;
    logic [2:0] a;
    logic [2:0] d;
  } exp_t;

  exp_t exp_q[$];
  bit   hist[$];     // value each clk edge effectively loaded into sync[0]
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 0;

  // Reference: din_sync is the sample taken S-1 edges ago, prev the one S edges ago;
  // a reset edge wipes every earlier sample.
  task automatic model_edge(input logic r_v, input logic d_v);
    exp_t e;
    int   n;
    if (!r_v) begin
      foreach (hist[i]) hist[i] = 1'b0;
      hist.push_back(1'b0);
    end else begin
      hist.push_back(d_v);
    end
    if (hist.size() > 8) void'(hist.pop_front());
    n = hist.size() - 1;
    for (int s = 1; s <= 3; s++) begin
      bit cur, prv;
      cur = hist[n - (s - 1)];
      prv = hist[n - s];
      e.d[s-1] = cur;
      e.r[s-1] = cur & ~prv;
      e.f[s-1] = ~cur & prv;
      e.a[s-1] = cur ^ prv;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r_v, input logic d_v, input bit glitch = 1'b0);
    rst = r_v;
    din = glitch ? 1'b0 : d_v;
    @(posedge clk);
    model_edge(r_v, din);
    #1;
    if (glitch) begin
      din = 1'b1;
      #3;
      din = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int s, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s S=%0d at %0t: got %b expected %b", name, s, $time, act, expv);
    end
  endtask

  // Monitor: every cycle is an output beat once an expectation is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int s = 0; s < 3; s++) begin
        chk("din_sync",     s + 1, dsync[s], e.d[s]);
        chk("rising_edge",  s + 1, rise[s],  e.r[s]);
        chk("falling_edge", s + 1, fall[s],  e.f[s]);
        chk("any_edge",     s + 1, anye[s],  e.a[s]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) hist.push_back(1'b0);
    #1;
    // reset with din high, then release: one rising pulse per build
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    // single step held 10 cycles
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    // sub-cycle glitch
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    // toggle every cycle
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    // reset landing on the cycle a pulse would still be high
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    // randomized traffic with runs, glitches and occasional resets
    for (int i = 0; i < 400; i++) begin
      logic r_v, d_v;
      bit   g;
      r_v = ($urandom_range(0, 19) != 0);
      d_v = ($urandom_range(0, 3) == 0) ? ~din : din;
      g   = (d_v == 1'b0) && ($urandom_range(0, 9) == 0);
      step(r_v, d_v, g);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    stim_done = 1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
`default_nettype wire
